id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
REQ-002 Hold  in  1  freeze request from downstream; all EX-side registers keep their value.
REQ-003 Flush  in  1  branch/jump taken in ID; the instruction in ID is squashed.
REQ-004 Control inputs  in  1 each:
- RegWrite_id, MemRead_id, MemWrite_id, MemToReg_id
- RegDst_id, ALUSrcA_id, ALUSrcB_id
REQ-005 ALUCode_id  in  5  ALU operation code.
REQ-006 Imm_id, Sa_id  in  32 each  extended immediate and shift amount.
REQ-007 RsAddr_id, RtAddr_id, RdAddr_id  in  5 each  register specifiers.
REQ-008 RsData_id, RtData_id  in  32 each  register-file read data.
REQ-009 Registered outputs: for every input X_id there SHALL be an output X_ex of identical width, driven directly from a flop.
REQ-010 Stall  out  1  combinational load-use hazard; upstream holds PC and the IF/ID register while Stall=1.
REQ-011 StallCount  out  32  bubble counter (see Configuration).

Function
REQ-012 Stall SHALL be 1 iff all of the following hold; otherwise 0:
- MemRead_ex=1
- RtAddr_ex!=0
- RtAddr_ex==RsAddr_id or RtAddr_ex==RtAddr_id
REQ-013 Stall SHALL be computed regardless of Hold and Flush.
REQ-014 Register update priority at each rising clk, highest first:
- rst: clear
- Hold=1: keep current values
- Flush=1 or Stall=1: load a bubble
- otherwise: load all X_id into X_ex
REQ-015 Bubble SHALL mean every X_ex field is loaded with 0, identical to the reset value.
REQ-016 Latency SHALL be exactly one cycle from X_id to X_ex when no Hold, Flush or Stall is active.
REQ-017 Flush and Stall asserted in the same cycle SHALL insert exactly one bubble.
REQ-018 Hold=1 together with Stall=1 SHALL insert no bubble; Stall stays asserted until Hold is released.
REQ-019 Back-to-back loads: a second load-use hazard after a bubble SHALL be evaluated afresh; a bubble has MemRead_ex=0, so Stall is never asserted for two consecutive cycles by the same load.
REQ-020 The block SHALL perform no forwarding; forwarding is handled downstream in EX.

Reset
REQ-021 rst=1 at a rising clk SHALL clear every X_ex output to 0; this takes priority over Hold, Flush and Stall.
REQ-022 During and after reset, Stall SHALL be 0, since MemRead_ex=0.
REQ-023 rst mid-stall SHALL discard the pending hazard; no bubble is counted in that cycle.

Configuration
REQ-024 With macro STALL_COUNTER_EN defined, StallCount SHALL:
- increment by 1 on each rising clk where a bubble is loaded due to Stall=1, including when Flush=1 in the same cycle
- wrap from 32'hFFFFFFFF to 0
- be cleared by rst
REQ-025 With STALL_COUNTER_EN undefined, StallCount SHALL be constant 0 with no counter flops; the port is present in both builds.

Verification
REQ-026 Pass-through: ALUCode_id=5'd3, RsData_id=32'h1234 at cycle n -> ALUCode_ex=3, RsData_ex=32'h1234 at cycle n+1, Stall=0.
REQ-027 Load-use: MemRead_ex=1, RtAddr_ex=5, RsAddr_id=5 -> Stall=1; next cycle all _ex=0, Stall=0, StallCount +1 when enabled.
REQ-028 Zero register: MemRead_ex=1, RtAddr_ex=0, RtAddr_id=0 -> Stall=0, normal load.
REQ-029 Hold over hazard: Hold=1 for 3 cycles with Stall=1 -> _ex unchanged 3 cycles; bubble on first cycle with Hold=0.
REQ-030 Flush and rst:
- Flush=1 with RegWrite_id=1 -> RegWrite_ex=0 next cycle
- rst=1 with Hold=1 -> all _ex=0 and StallCount=0
REQ-031 Wrap: StallCount preset via 2^32-1 stall events (or forced) plus one more stall -> StallCount=0.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional bubble counter on StallCount is built only when STALL_COUNTER_EN is defined.
module id_ex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        Hold,
  input  logic        Flush,
  input  logic        RegWrite_id,
  input  logic        MemRead_id,
  input  logic        MemWrite_id,
  input  logic        MemToReg_id,
  input  logic        RegDst_id,
  input  logic        ALUSrcA_id,
  input  logic        ALUSrcB_id,
  input  logic [4:0]  ALUCode_id,
  input  logic [31:0] Imm_id,
  input  logic [31:0] Sa_id,
  input  logic [4:0]  RsAddr_id,
  input  logic [4:0]  RtAddr_id,
  input  logic [4:0]  RdAddr_id,
  input  logic [31:0] RsData_id,
  input  logic [31:0] RtData_id,
  output logic        RegWrite_ex,
  output logic        MemRead_ex,
  output logic        MemWrite_ex,
  output logic        MemToReg_ex,
  output logic        RegDst_ex,
  output logic        ALUSrcA_ex,
  output logic        ALUSrcB_ex,
  output logic [4:0]  ALUCode_ex,
  output logic [31:0] Imm_ex,
  output logic [31:0] Sa_ex,
  output logic [4:0]  RsAddr_ex,
  output logic [4:0]  RtAddr_ex,
  output logic [4:0]  RdAddr_ex,
  output logic [31:0] RsData_ex,
  output logic [31:0] RtData_ex,
  output logic        Stall,
  output logic [31:0] StallCount
);

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        alu_src_a;
    logic        alu_src_b;
    logic [4:0]  alu_code;
    logic [31:0] imm;
    logic [31:0] sa;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
  } ex_fields_t;

  ex_fields_t id_fields;
  ex_fields_t ex_d, ex_q;
  logic       stall;

  always_comb begin
    id_fields            = '0;
    id_fields.reg_write  = RegWrite_id;
    id_fields.mem_read   = MemRead_id;
    id_fields.mem_write  = MemWrite_id;
    id_fields.mem_to_reg = MemToReg_id;
    id_fields.reg_dst    = RegDst_id;
    id_fields.alu_src_a  = ALUSrcA_id;
    id_fields.alu_src_b  = ALUSrcB_id;
    id_fields.alu_code   = ALUCode_id;
    id_fields.imm        = Imm_id;
    id_fields.sa         = Sa_id;
    id_fields.rs_addr    = RsAddr_id;
    id_fields.rt_addr    = RtAddr_id;
    id_fields.rd_addr    = RdAddr_id;
    id_fields.rs_data    = RsData_id;
    id_fields.rt_data    = RtData_id;
  end

  // Load in EX whose destination is read by the instruction in ID; $zero never hazards.
  always_comb begin
    stall = 1'b0;
    if (ex_q.mem_read && (ex_q.rt_addr != 5'd0) &&
        ((ex_q.rt_addr == RsAddr_id) || (ex_q.rt_addr == RtAddr_id))) begin
      stall = 1'b1;
    end
  end

  always_comb begin
    ex_d = ex_q;
    if (!Hold) begin
      if (Flush || stall) begin
        ex_d = '0;
      end else begin
        ex_d = id_fields;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign RegWrite_ex = ex_q.reg_write;
  assign MemRead_ex  = ex_q.mem_read;
  assign MemWrite_ex = ex_q.mem_write;
  assign MemToReg_ex = ex_q.mem_to_reg;
  assign RegDst_ex   = ex_q.reg_dst;
  assign ALUSrcA_ex  = ex_q.alu_src_a;
  assign ALUSrcB_ex  = ex_q.alu_src_b;
  assign ALUCode_ex  = ex_q.alu_code;
  assign Imm_ex      = ex_q.imm;
  assign Sa_ex       = ex_q.sa;
  assign RsAddr_ex   = ex_q.rs_addr;
  assign RtAddr_ex   = ex_q.rt_addr;
  assign RdAddr_ex   = ex_q.rd_addr;
  assign RsData_ex   = ex_q.rs_data;
  assign RtData_ex   = ex_q.rt_data;
  assign Stall       = stall;

`ifdef STALL_COUNTER_EN
  logic [31:0] stall_count_d, stall_count_q;

  // Counts only hazard bubbles; a flush-only bubble does not count, a held cycle never does.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!Hold && stall) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign StallCount = stall_count_q;
`else
  assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios then random traffic,
// compared against a cycle-level reference model of the pipeline register.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst, Hold, Flush;
  logic        RegWrite_id, MemRead_id, MemWrite_id, MemToReg_id;
  logic        RegDst_id, ALUSrcA_id, ALUSrcB_id;
  logic [4:0]  ALUCode_id, RsAddr_id, RtAddr_id, RdAddr_id;
  logic [31:0] Imm_id, Sa_id, RsData_id, RtData_id;

  logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemToReg_ex;
  logic        RegDst_ex, ALUSrcA_ex, ALUSrcB_ex;
  logic [4:0]  ALUCode_ex, RsAddr_ex, RtAddr_ex, RdAddr_ex;
  logic [31:0] Imm_ex, Sa_ex, RsData_ex, RtData_ex;
  logic        Stall;
  logic [31:0] StallCount;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct packed {
    logic        rw, mr, mw, m2r, rdst, srca, srcb;
    logic [4:0]  alu;
    logic [31:0] imm, sa;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd;
  } fields_t;

  fields_t     m_ex;
  logic [31:0] m_cnt;
  bit          m_valid = 0;
  bit          cnt_en;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .Hold(Hold), .Flush(Flush),
    .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id),
    .MemToReg_id(MemToReg_id), .RegDst_id(RegDst_id), .ALUSrcA_id(ALUSrcA_id),
    .ALUSrcB_id(ALUSrcB_id), .ALUCode_id(ALUCode_id), .Imm_id(Imm_id), .Sa_id(Sa_id),
    .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id), .RdAddr_id(RdAddr_id),
    .RsData_id(RsData_id), .RtData_id(RtData_id),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .MemToReg_ex(MemToReg_ex), .RegDst_ex(RegDst_ex), .ALUSrcA_ex(ALUSrcA_ex),
    .ALUSrcB_ex(ALUSrcB_ex), .ALUCode_ex(ALUCode_ex), .Imm_ex(Imm_ex), .Sa_ex(Sa_ex),
    .RsAddr_ex(RsAddr_ex), .RtAddr_ex(RtAddr_ex), .RdAddr_ex(RdAddr_ex),
    .RsData_ex(RsData_ex), .RtData_ex(RtData_ex),
    .Stall(Stall), .StallCount(StallCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic fields_t id_now();
    fields_t f;
    f = '{rw: RegWrite_id, mr: MemRead_id, mw: MemWrite_id, m2r: MemToReg_id,
          rdst: RegDst_id, srca: ALUSrcA_id, srcb: ALUSrcB_id, alu: ALUCode_id,
          imm: Imm_id, sa: Sa_id, rs: RsAddr_id, rt: RtAddr_id, rd: RdAddr_id,
          rsd: RsData_id, rtd: RtData_id};
    return f;
  endfunction

  function automatic fields_t ex_now();
    fields_t f;
    f = '{rw: RegWrite_ex, mr: MemRead_ex, mw: MemWrite_ex, m2r: MemToReg_ex,
          rdst: RegDst_ex, srca: ALUSrcA_ex, srcb: ALUSrcB_ex, alu: ALUCode_ex,
          imm: Imm_ex, sa: Sa_ex, rs: RsAddr_ex, rt: RtAddr_ex, rd: RdAddr_ex,
          rsd: RsData_ex, rtd: RtData_ex};
    return f;
  endfunction

  task automatic clear_inputs();
    {RegWrite_id, MemRead_id, MemWrite_id, MemToReg_id} = '0;
    {RegDst_id, ALUSrcA_id, ALUSrcB_id} = '0;
    {ALUCode_id, RsAddr_id, RtAddr_id, RdAddr_id} = '0;
    {Imm_id, Sa_id, RsData_id, RtData_id} = '0;
    {rst, Hold, Flush} = '0;
  endtask

  task automatic rand_inputs();
    {RegWrite_id, MemWrite_id, MemToReg_id, RegDst_id} = 4'($urandom);
    {ALUSrcA_id, ALUSrcB_id} = 2'($urandom);
    MemRead_id = ($urandom_range(0, 1) == 1);
    ALUCode_id = 5'($urandom);
    Imm_id = $urandom; Sa_id = $urandom; RsData_id = $urandom; RtData_id = $urandom;
    // Narrow address range so load-use hazards occur often.
    RsAddr_id = 5'($urandom_range(0, 3));
    RtAddr_id = 5'($urandom_range(0, 3));
    RdAddr_id = 5'($urandom);
    rst   = ($urandom_range(0, 99) < 3);
    Hold  = ($urandom_range(0, 99) < 20);
    Flush = ($urandom_range(0, 99) < 15);
  endtask

  // One clock: check Stall before the edge, advance the model, check registers after it.
  task automatic step(input string tag);
    bit      hz;
    fields_t cur;
    @(negedge clk);
    #1;
    cur = id_now();
    hz = m_ex.mr && (m_ex.rt != 5'd0) && ((m_ex.rt == cur.rs) || (m_ex.rt == cur.rt));
    if (m_valid) chk({tag, ".stall"}, 32'(Stall), 32'(hz));
    @(posedge clk);
    if (rst) begin
      m_ex = '0; m_cnt = '0; m_valid = 1;
    end else if (m_valid && !Hold) begin
      if (hz) m_cnt = m_cnt + 32'd1;
      m_ex = (Flush || hz) ? fields_t'('0) : cur;
    end
    #1;
    if (m_valid) begin
      tests++;
      assert (ex_now() === m_ex) else begin
        fails++;
        $error("FAIL %s.ex: observed %h expected %h", tag, ex_now(), m_ex);
      end
      chk({tag, ".cnt"}, StallCount, cnt_en ? m_cnt : 32'd0);
    end
  endtask

  initial begin
`ifdef STALL_COUNTER_EN
    cnt_en = 1;
`else
    cnt_en = 0;
`endif
    m_ex = '0; m_cnt = '0;
    clear_inputs();
    rst = 1'b1; Hold = 1'b1; Flush = 1'b1; RegWrite_id = 1'b1;
    step("reset");
    step("reset2");
    chk("reset.regwrite", 32'(RegWrite_ex), 32'd0);
    chk("reset.stall", 32'(Stall), 32'd0);

    // Pass-through
    clear_inputs();
    ALUCode_id = 5'd3; RsData_id = 32'h1234;
    step("pass");
    chk("pass.alucode", 32'(ALUCode_ex), 32'd3);
    chk("pass.rsdata", RsData_ex, 32'h1234);

    // Load-use: load to r5, then consumer reading r5 as rs
    clear_inputs();
    MemRead_id = 1'b1; RtAddr_id = 5'd5; RegWrite_id = 1'b1;
    step("load");
    MemRead_id = 1'b0; RtAddr_id = 5'd7; RsAddr_id = 5'd5; ALUCode_id = 5'd9;
    step("loaduse");
    chk("loaduse.bubble_mr", 32'(MemRead_ex), 32'd0);
    chk("loaduse.bubble_alu", 32'(ALUCode_ex), 32'd0);
    step("loaduse.after");
    chk("loaduse.after_alu", 32'(ALUCode_ex), 32'd9);

    // Zero register never hazards
    clear_inputs();
    MemRead_id = 1'b1; RtAddr_id = 5'd0; RegWrite_id = 1'b1;
    step("zload");
    MemRead_id = 1'b0; ALUCode_id = 5'd4;
    step("zuse");
    chk("zuse.alu", 32'(ALUCode_ex), 32'd4);

    // Hold over a pending hazard for 3 cycles, then one bubble
    clear_inputs();
    MemRead_id = 1'b1; RtAddr_id = 5'd6; Imm_id = 32'hdead_beef;
    step("hload");
    MemRead_id = 1'b0; RtAddr_id = 5'd6; Hold = 1'b1;
    for (int i = 0; i < 3; i++) step("hold");
    chk("hold.imm", Imm_ex, 32'hdead_beef);
    Hold = 1'b0;
    step("hold.release");
    chk("hold.bubble", Imm_ex, 32'd0);

    // Flush alone, and flush coinciding with a stall
    clear_inputs();
    RegWrite_id = 1'b1; Flush = 1'b1;
    step("flush");
    chk("flush.regwrite", 32'(RegWrite_ex), 32'd0);
    Flush = 1'b0; MemRead_id = 1'b1; RtAddr_id = 5'd2;
    step("fload");
    MemRead_id = 1'b0; RsAddr_id = 5'd2; Flush = 1'b1;
    step("flush+stall");
    Flush = 1'b0;
    step("flush+stall.after");

    // Reset mid-stall with Hold
    clear_inputs();
    MemRead_id = 1'b1; RtAddr_id = 5'd3;
    step("rload");
    MemRead_id = 1'b0; RsAddr_id = 5'd3; rst = 1'b1; Hold = 1'b1;
    step("rst.hold");
    chk("rst.cnt", StallCount, 32'd0);
    chk("rst.mr", 32'(MemRead_ex), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
